// File: rtl/led_pkg.sv
// Shared constants and helpers for the LED output stage and its companion blocks.
package led_pkg;

  localparam int unsigned LED_WIDTH   = 14;
  localparam int unsigned PWM_SLOTS   = 16;
  localparam int unsigned PHASE_WIDTH = 4;
  localparam int unsigned DUTY_WIDTH  = 5;
  localparam int unsigned DUTY_MAX    = 16;

  localparam logic [LED_WIDTH-1:0] LED_ALL_ON = 14'h3FFF;

  // Requests above a full frame mean "always on".
  function automatic logic [DUTY_WIDTH-1:0] clamp_duty(input logic [DUTY_WIDTH-1:0] d);
    return (d > DUTY_WIDTH'(DUTY_MAX)) ? DUTY_WIDTH'(DUTY_MAX) : d;
  endfunction

endpackage

// File: rtl/led_prescaler.sv
// Free-running slot prescaler: counts 0..PRESCALE-1 and flags the wrap and zero cycles.
module led_prescaler #(
  parameter int unsigned PRESCALE = 1024
) (
  input  logic clock,
  input  logic reset,
  output logic tick,
  output logic at_zero
);

  localparam int unsigned PRE_WIDTH = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_WIDTH-1:0] PRE_LAST = PRE_WIDTH'(PRESCALE - 1);

  logic [PRE_WIDTH-1:0] pre;

  // tick/at_zero are decoded combinationally so the consumer can act in the same cycle.
  assign tick    = (pre == PRE_LAST);
  assign at_zero = (pre == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PRE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/led_pwm_driver.sv
// Frame-aligned PWM brightness and lamp-test stage between the LED register and the pins.
module led_pwm_driver
  import led_pkg::*;
#(
  parameter int unsigned PRESCALE = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [LED_WIDTH-1:0]  led_in,
  input  logic [DUTY_WIDTH-1:0] duty,
  input  logic                  lamp_test,
  output logic [LED_WIDTH-1:0]  LED,
  output logic                  frame_start
);

  logic                   tick;
  logic                   at_zero;
  logic [PHASE_WIDTH-1:0] phase;
  logic [LED_WIDTH-1:0]   led_sh;
  logic [LED_WIDTH-1:0]   led_sh_nxt;
  logic [DUTY_WIDTH-1:0]  duty_sh;
  logic [DUTY_WIDTH-1:0]  duty_sh_nxt;
  logic                   load;
  logic                   window;

  led_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock   (clock),
    .reset   (reset),
    .tick    (tick),
    .at_zero (at_zero)
  );

  // Output compare runs on next-state shadows so a load cycle already shows the new frame.
  always_comb begin
    load        = at_zero && (phase == '0);
    led_sh_nxt  = led_sh;
    duty_sh_nxt = duty_sh;
    if (load) begin
      led_sh_nxt  = led_in;
      duty_sh_nxt = clamp_duty(duty);
    end
    window = (DUTY_WIDTH'(phase) < duty_sh_nxt);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase       <= '0;
      led_sh      <= '0;
      duty_sh     <= '0;
      LED         <= '0;
      frame_start <= 1'b0;
    end else begin
      if (tick) begin
        phase <= phase + PHASE_WIDTH'(1);
      end
      led_sh      <= led_sh_nxt;
      duty_sh     <= duty_sh_nxt;
      frame_start <= load;
      LED         <= lamp_test ? LED_ALL_ON : (window ? led_sh_nxt : '0);
    end
  end

endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed and randomized bench for led_pwm_driver at PRESCALE=4 and the PRESCALE=1 boundary.
module tb_led_pwm_driver;

  logic        clock = 1'b0;
  logic        reset;
  logic [13:0] led_in;
  logic [4:0]  duty;
  logic        lamp_test;
  logic [13:0] led_a, led_b;
  logic        fs_a, fs_b;

  int checks = 0;
  int errors = 0;

  // Reference state: cycles since reset release, plus per-instance frame shadows.
  int          t = 0;
  logic [13:0] m_led [2];
  int          m_duty [2];
  logic [13:0] exp_led [2];
  logic        exp_fs [2];

  always #5 clock = ~clock;

  led_pwm_driver #(.PRESCALE(4)) dut_a (
    .clock       (clock),
    .reset       (reset),
    .led_in      (led_in),
    .duty        (duty),
    .lamp_test   (lamp_test),
    .LED         (led_a),
    .frame_start (fs_a)
  );

  led_pwm_driver #(.PRESCALE(1)) dut_b (
    .clock       (clock),
    .reset       (reset),
    .led_in      (led_in),
    .duty        (duty),
    .lamp_test   (lamp_test),
    .LED         (led_b),
    .frame_start (fs_b)
  );

  task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: model the frame from elapsed time, then compare both instances.
  task automatic step();
    @(posedge clock);
    for (int k = 0; k < 2; k++) begin
      int p;
      int pos;
      p = (k == 0) ? 4 : 1;
      if (reset) begin
        m_led[k]   = '0;
        m_duty[k]  = 0;
        exp_led[k] = '0;
        exp_fs[k]  = 1'b0;
      end else begin
        pos = t % (16 * p);
        if (pos == 0) begin
          m_led[k]  = led_in;
          m_duty[k] = (int'(duty) > 16) ? 16 : int'(duty);
        end
        exp_led[k] = lamp_test ? 14'h3FFF : (((pos / p) < m_duty[k]) ? m_led[k] : 14'h0);
        exp_fs[k]  = (pos == 0);
      end
    end
    if (reset) t = 0;
    else t++;
    #1;
    chk("led_p4", led_a, exp_led[0]);
    chk("fs_p4", 14'(fs_a), 14'(exp_fs[0]));
    chk("led_p1", led_b, exp_led[1]);
    chk("fs_p1", 14'(fs_b), 14'(exp_fs[1]));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until the next edge sampled is frame position pos of the PRESCALE=4 instance.
  task automatic goto_pos(input int pos);
    for (int i = 0; i < 64 && (t % 64) != pos; i++) step();
  endtask

  // Run one aligned frame, counting lit cycles and frame_start pulses.
  task automatic run_frame(output int on_cnt, output int fs_cnt);
    on_cnt = 0;
    fs_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (led_a != 14'h0) on_cnt++;
      if (fs_a) fs_cnt++;
    end
  endtask

  initial begin
    int on_cnt, fs_cnt;
    int duties [4];
    int want [4];
    duties = '{0, 1, 16, 31};
    want   = '{0, 4, 64, 64};

    reset = 1'b1; led_in = 14'h3FFF; duty = 5'd16; lamp_test = 1'b0;

    // Reset hold
    for (int i = 0; i < 5; i++) begin
      step();
      chk("reset_hold_led", led_a, 14'h0);
      chk("reset_hold_fs", 14'(fs_a), 14'h0);
    end
    reset = 1'b0;
    step();
    chk("release_fs", 14'(fs_a), 14'h1);
    chk("release_led", led_a, 14'h3FFF);

    // Half duty
    led_in = 14'h2A5A; duty = 5'd8;
    goto_pos(0);
    for (int f = 0; f < 2; f++) begin
      run_frame(on_cnt, fs_cnt);
      chk("half_on_cycles", 14'(on_cnt), 14'd32);
      chk("half_fs_pulses", 14'(fs_cnt), 14'd1);
    end

    // Duty extremes
    for (int j = 0; j < 4; j++) begin
      duty = 5'(duties[j]);
      goto_pos(0);
      run_frame(on_cnt, fs_cnt);
      chk("extreme_on_cycles", 14'(on_cnt), 14'(want[j]));
    end

    // Mid-frame rewrite
    duty = 5'd8; led_in = 14'h2A5A;
    goto_pos(0);
    steps(10);
    led_in = 14'h0155; duty = 5'd4;
    goto_pos(0);
    run_frame(on_cnt, fs_cnt);
    chk("rewrite_on_cycles", 14'(on_cnt), 14'd16);

    // Lamp test over a dark frame
    duty = 5'd0;
    goto_pos(0);
    steps(1);
    goto_pos(20);
    lamp_test = 1'b1;
    steps(7);
    lamp_test = 1'b0;
    steps(1);
    chk("lamp_release_led", led_a, 14'h0);
    goto_pos(0);

    // Mid-frame reset
    duty = 5'd16; led_in = 14'h1234;
    steps(1);
    goto_pos(30);
    reset = 1'b1;
    step();
    chk("midreset_led", led_a, 14'h0);
    reset = 1'b0;
    step();
    chk("midreset_fs", 14'(fs_a), 14'h1);
    chk("midreset_led_back", led_a, 14'h1234);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      led_in    = 14'($urandom);
      if ($urandom_range(0, 7) == 0) duty = 5'($urandom);
      lamp_test = ($urandom_range(0, 15) == 0);
      reset     = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0; lamp_test = 1'b0;
    steps(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
